video_palette: RTL and testbench
================================

// Module: video_palette
// PURPOSE
// - Parametrised video output stage between the video generator (pixel/color/hsync/vsync/ce_pix) and video_mixer.
// - Replaces a fixed 16-entry palette ROM with a multi-bank, run-time writable palette RAM.
// - Adds blanking, an optional monochrome (luma) mode and sync delay matched to the pixel path.
// - A reset-time init FSM loads the built-in Colour Genie colour table into every bank.
// PARAMETERS
// - IDXW   4  colour index width; 2**IDXW entries per bank
// - CHW    6  bits per channel; rgb_out is {R,G,B}, each CHW bits
// - BANKS  2  number of palette banks (>=1); BW = max(1,$clog2(BANKS))
// PORTS
// - clock     in   1       system clock; single clock domain
// - reset     in   1       synchronous, active-high reset
// - ce_pix    in   1       pixel clock enable; the lookup pipeline advances only when high
// - pixel     in   1       1 = active display, 0 = blank
// - color     in   IDXW    palette index
// - hsync     in   1       horizontal sync, passed through delayed
// - vsync     in   1       vertical sync, passed through delayed
// - bank      in   BW      palette bank used for lookups
// - mono      in   1       1 = output grey luma instead of colour
// - wr_en     in   1       palette write strobe, one clock
// - wr_bank   in   BW      bank to write
// - wr_idx    in   IDXW    entry to write
// - wr_rgb    in   3*CHW   new {R,G,B} value
// - wr_busy   out  1       1 = writes are ignored (INIT)
// - init_done out  1       1 = palette loaded (RUN)
// - rgb_out   out  3*CHW   pixel colour to the mixer
// - hs_out    out  1       hsync, aligned with rgb_out
// - vs_out    out  1       vsync, aligned with rgb_out
// BEHAVIOUR
// - FSM states INIT and RUN. reset forces INIT with cnt=0.
// - Reset values: rgb_out=0, hs_out=0, vs_out=0, wr_busy=1, init_done=0.
// - INIT: one entry per clock, independent of ce_pix.
//   - Entry {bank=cnt/2**IDXW, idx=cnt%2**IDXW} <= DEFAULT[idx[3:0]]; the default table is defined at 6-bit/channel and MSB-aligned to CHW.
//   - After entry BANKS*2**IDXW-1 is written, go to RUN: wr_busy=0 and init_done=1 from the next clock.
//   - reset asserted mid-INIT restarts cnt at 0. The FSM never returns to INIT without reset.
// - DEFAULT table, idx 0..15, RGB 6-bit each:
//   - idx 0..7: 10,10,10 | 18,38,38 | 30,08,10 | 38,38,38 | 38,38,08 | 28,38,10 | 38,18,08 | 30,38,08 (hex)
//   - idx 8..15: 08,10,38 | 28,30,38 | 30,10,38 | 20,18,38 | 20,20,20 | 08,30,20 | 20,08,38 | 38,38,38 (hex)
// - Write port:
//   - In RUN, wr_en=1 writes wr_rgb to [wr_bank][wr_idx] at that edge; no ack is given and there is no back-pressure.
//   - wr_en during INIT (wr_busy=1) is dropped.
//   - wr_bank >= BANKS: the write is dropped.
// - Lookup pipeline, 2 stages, each advancing on clock when ce_pix=1:
//   - S1 registers palette[bank][color], pixel, hsync and vsync. bank >= BANKS reads bank 0.
//   - Read-before-write: a lookup of an entry in the same clock as its write returns the old value; the new value is visible from the next clock.
//   - S2: blank (S1 pixel=0 or state INIT) gives rgb_out=0. Otherwise, if mono: Y=(R+2G+B)>>2, sum computed at CHW+2 bits, result truncated to CHW, rgb_out={Y,Y,Y}. Otherwise rgb_out=palette value.
//   - hs_out/vs_out are S1 syncs registered with the same enable, so syncs keep running during INIT.
// - Latency is exactly 2 ce_pix-enabled edges from inputs to rgb_out/hs_out/vs_out; inputs are sampled only when ce_pix=1.
// - ce_pix=0: every pipeline register and output holds its value.
// - bank/mono changes take effect on the next sampled pixel; there is no frame alignment.
// TESTING
// - Defaults (IDXW=4, CHW=6, BANKS=2); reset 1 clk, then release -> init_done=0, wr_busy=1 for exactly 32 clocks, then both flip.
// - After init: ce_pix=1, pixel=1, bank=0, color=2, hsync pulse -> rgb_out=18'b110000_001000_010000 and hs_out pulse, both 2 clocks later.
// - pixel=0, color=15 -> rgb_out=0 two ce_pix later; hs/vs still delayed by 2; ce_pix=0 for 5 clocks -> all outputs frozen.
// - wr_en, wr_bank=1, wr_idx=5, wr_rgb={6'h3F,6'h00,6'h00}; then lookup bank1/color5 -> rgb_out={3F,00,00}; bank0/color5 -> 18'b101000_111000_010000; same-clock read of bank1/color5 -> old value.
// - mono=1: color 2 -> (48+16+16)>>2=20 -> rgb_out={6'd20,6'd20,6'd20}; color 15 -> {56,56,56}.
// - reset re-asserted at INIT clock 10 while wr_en pulses -> writes dropped; init_done rises 32 clocks after release; all entries hold defaults.

Source files
------------

// File: rtl/video_palette.sv
// video_palette: video output stage between the video generator and video_mixer.
//   Multi-bank run-time writable palette RAM, loaded with the Colour Genie
//   colour table by an init FSM after reset. Two-stage lookup pipeline gated by
//   ce_pix, with blanking, optional grey (luma) output and matched sync delay.
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   ce_pix               pixel enable; lookup pipeline advances only when high
//   pixel/color          active-display flag and palette index
//   hsync/vsync          syncs, delayed to line up with rgb_out
//   bank/mono            lookup bank select and grey-output select
//   wr_en/wr_bank/wr_idx/wr_rgb  palette write port (ignored while wr_busy)
//   wr_busy/init_done    init FSM status
//   rgb_out/hs_out/vs_out  {R,G,B} pixel and syncs to the mixer
module video_palette #(
  parameter int IDXW  = 4,
  parameter int CHW   = 6,
  parameter int BANKS = 2,
  parameter int BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              pixel,
  input  logic [IDXW-1:0]   color,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [BW-1:0]     bank,
  input  logic              mono,
  input  logic              wr_en,
  input  logic [BW-1:0]     wr_bank,
  input  logic [IDXW-1:0]   wr_idx,
  input  logic [3*CHW-1:0]  wr_rgb,
  output logic              wr_busy,
  output logic              init_done,
  output logic [3*CHW-1:0]  rgb_out,
  output logic              hs_out,
  output logic              vs_out
);

  localparam int NE   = 2**IDXW;
  localparam int TOT  = BANKS * NE;
  localparam int CW   = $clog2(TOT + 1);
  localparam int RGBW = 3 * CHW;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic            pix;
    logic            hs;
    logic            vs;
    logic            mono;
    logic [RGBW-1:0] rgb;
  } s1_t;

  // Built-in table is 6 bits/channel; widen or narrow keeping the MSBs.
  function automatic logic [CHW-1:0] msb_align(input logic [5:0] c);
    logic [CHW+5:0] t;
    t = {c, {CHW{1'b0}}};
    return t[CHW+5 -: CHW];
  endfunction

  function automatic logic [RGBW-1:0] dflt(input logic [3:0] i);
    logic [17:0] t;
    case (i)
      4'd0:    t = {6'h10, 6'h10, 6'h10};
      4'd1:    t = {6'h18, 6'h38, 6'h38};
      4'd2:    t = {6'h30, 6'h08, 6'h10};
      4'd3:    t = {6'h38, 6'h38, 6'h38};
      4'd4:    t = {6'h38, 6'h38, 6'h08};
      4'd5:    t = {6'h28, 6'h38, 6'h10};
      4'd6:    t = {6'h38, 6'h18, 6'h08};
      4'd7:    t = {6'h30, 6'h38, 6'h08};
      4'd8:    t = {6'h08, 6'h10, 6'h38};
      4'd9:    t = {6'h28, 6'h30, 6'h38};
      4'd10:   t = {6'h30, 6'h10, 6'h38};
      4'd11:   t = {6'h20, 6'h18, 6'h38};
      4'd12:   t = {6'h20, 6'h20, 6'h20};
      4'd13:   t = {6'h08, 6'h30, 6'h20};
      4'd14:   t = {6'h20, 6'h08, 6'h38};
      default: t = {6'h38, 6'h38, 6'h38};
    endcase
    return {msb_align(t[17:12]), msb_align(t[11:6]), msb_align(t[5:0])};
  endfunction

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  // palette RAM; no reset, the init FSM overwrites every entry
  logic [BANKS-1:0][NE-1:0][RGBW-1:0] pal;

  logic [BW-1:0]   ib;
  logic [IDXW-1:0] ii;
  logic [BW-1:0]   rd_bank;
  logic [RGBW-1:0] rd_rgb;

  s1_t s1;

  logic [CHW+1:0]  luma_sum;
  logic [CHW-1:0]  luma;
  logic [RGBW-1:0] s2_rgb;

  // ---------------- init FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == INIT) begin
      cnt_nxt = cnt + CW'(1);
      if (cnt == CW'(TOT - 1)) state_nxt = RUN;
    end
  end

  assign wr_busy   = (state == INIT);
  assign init_done = (state == RUN);

  // ---------------- palette write ----------------
  assign ib = BW'(cnt >> IDXW);
  assign ii = IDXW'(cnt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == INIT)
        pal[ib][ii] <= dflt(4'(ii));
      else if (wr_en && int'(wr_bank) < BANKS)
        pal[wr_bank][wr_idx] <= wr_rgb;
    end
  end

  // ---------------- lookup pipeline ----------------
  // Registered read from the pre-edge array: a same-edge write is seen next clock.
  assign rd_bank = (int'(bank) < BANKS) ? bank : '0;
  assign rd_rgb  = pal[rd_bank][color];

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
    end else if (ce_pix) begin
      s1.pix  <= pixel;
      s1.hs   <= hsync;
      s1.vs   <= vsync;
      s1.mono <= mono;
      s1.rgb  <= rd_rgb;
    end
  end

  // Y = (R + 2G + B) >> 2, sum held at CHW+2 bits so it cannot overflow
  assign luma_sum = {2'b00, s1.rgb[RGBW-1 -: CHW]}
                  + {1'b0, s1.rgb[2*CHW-1 -: CHW], 1'b0}
                  + {2'b00, s1.rgb[CHW-1:0]};
  assign luma     = luma_sum[CHW+1:2];

  always_comb begin
    s2_rgb = s1.rgb;
    if (!s1.pix || state == INIT) s2_rgb = '0;
    else if (s1.mono)             s2_rgb = {luma, luma, luma};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rgb_out <= '0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
    end else if (ce_pix) begin
      rgb_out <= s2_rgb;
      hs_out  <= s1.hs;
      vs_out  <= s1.vs;
    end
  end

endmodule

// File: tb/tb_video_palette.sv
module tb_video_palette;

  logic        clock;
  logic        reset;
  logic        ce_pix;
  logic        pixel;
  logic [3:0]  color;
  logic        hsync;
  logic        vsync;
  logic [0:0]  bank;
  logic        mono;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [3:0]  wr_idx;
  logic [17:0] wr_rgb;
  logic        wr_busy;
  logic        init_done;
  logic [17:0] rgb_out;
  logic        hs_out;
  logic        vs_out;

  video_palette dut (
    .clock(clock), .reset(reset), .ce_pix(ce_pix), .pixel(pixel),
    .color(color), .hsync(hsync), .vsync(vsync), .bank(bank), .mono(mono),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
    .wr_busy(wr_busy), .init_done(init_done), .rgb_out(rgb_out),
    .hs_out(hs_out), .vs_out(vs_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [17:0] deftab [16];
  logic [17:0] mpal [2][16];
  int          init_left;
  logic        p_pix, p_hs, p_vs;
  logic [17:0] p_val;
  logic [17:0] ex_rgb;
  logic        ex_hs, ex_vs;

  initial begin
    deftab[0]  = {6'h10, 6'h10, 6'h10}; deftab[1]  = {6'h18, 6'h38, 6'h38};
    deftab[2]  = {6'h30, 6'h08, 6'h10}; deftab[3]  = {6'h38, 6'h38, 6'h38};
    deftab[4]  = {6'h38, 6'h38, 6'h08}; deftab[5]  = {6'h28, 6'h38, 6'h10};
    deftab[6]  = {6'h38, 6'h18, 6'h08}; deftab[7]  = {6'h30, 6'h38, 6'h08};
    deftab[8]  = {6'h08, 6'h10, 6'h38}; deftab[9]  = {6'h28, 6'h30, 6'h38};
    deftab[10] = {6'h30, 6'h10, 6'h38}; deftab[11] = {6'h20, 6'h18, 6'h38};
    deftab[12] = {6'h20, 6'h20, 6'h20}; deftab[13] = {6'h08, 6'h30, 6'h20};
    deftab[14] = {6'h20, 6'h08, 6'h38}; deftab[15] = {6'h38, 6'h38, 6'h38};
  end

  function automatic logic [17:0] grey(input logic [17:0] e);
    int y;
    y = (int'(e[17:12]) + 2 * int'(e[11:6]) + int'(e[5:0])) / 4;
    return {y[5:0], y[5:0], y[5:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, then check.
  task automatic cyc();
    logic        run;
    logic [17:0] e;
    @(posedge clock);
    if (reset) begin
      init_left = 32;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 16; i++) mpal[b][i] = deftab[i];
      ex_rgb = '0; ex_hs = 1'b0; ex_vs = 1'b0;
      p_pix = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_val = '0;
    end else begin
      run = (init_left == 0);
      if (ce_pix) begin
        ex_rgb = (p_pix && run) ? p_val : 18'd0;
        ex_hs  = p_hs;
        ex_vs  = p_vs;
        p_pix  = pixel;
        p_hs   = hsync;
        p_vs   = vsync;
        e      = mpal[bank][color];
        p_val  = mono ? grey(e) : e;
      end
      if (run && wr_en) mpal[wr_bank][wr_idx] = wr_rgb;
      if (init_left > 0) init_left--;
    end
    #1;
    chk("rgb_out",   32'(rgb_out),   32'(ex_rgb));
    chk("hs_out",    32'(hs_out),    32'(ex_hs));
    chk("vs_out",    32'(vs_out),    32'(ex_vs));
    chk("wr_busy",   32'(wr_busy),   32'(init_left != 0));
    chk("init_done", 32'(init_done), 32'(init_left == 0));
  endtask

  initial begin
    reset = 1'b1; ce_pix = 1'b0; pixel = 1'b0; color = '0; hsync = 1'b0;
    vsync = 1'b0; bank = '0; mono = 1'b0; wr_en = 1'b0; wr_bank = '0;
    wr_idx = '0; wr_rgb = '0;

    // reset state
    cyc();
    chk("reset_busy", 32'(wr_busy), 32'd1);
    reset = 1'b0;

    // init: 32 clocks busy, syncs keep running
    for (int i = 0; i < 34; i++) begin
      ce_pix = (i % 5) != 3;
      hsync  = (i % 8) == 1;
      vsync  = (i % 13) == 2;
      cyc();
      if (i == 30) chk("init_busy_31", 32'(init_done), 32'd0);
    end
    chk("init_done_after", 32'(init_done), 32'd1);
    ce_pix = 1'b1; hsync = 1'b0; vsync = 1'b0;
    cyc(); cyc();

    // colour 2 lookup with hsync pulse
    pixel = 1'b1; bank = 1'b0; color = 4'd2; hsync = 1'b1;
    cyc();
    hsync = 1'b0;
    cyc();
    chk("color2", 32'(rgb_out), 32'(18'b110000_001000_010000));
    chk("hs_pulse", 32'(hs_out), 32'd1);
    cyc();

    // blanking, vsync delay, then ce_pix hold
    pixel = 1'b0; color = 4'd15; vsync = 1'b1;
    cyc();
    vsync = 1'b0;
    cyc();
    chk("blank", 32'(rgb_out), 32'd0);
    chk("vs_pulse", 32'(vs_out), 32'd1);
    ce_pix = 1'b0; pixel = 1'b1; hsync = 1'b1; color = 4'd3;
    repeat (5) cyc();
    chk("hold_vs", 32'(vs_out), 32'd1);
    ce_pix = 1'b1; hsync = 1'b0; pixel = 1'b1;
    cyc(); cyc();

    // write bank1/idx5 with same-clock lookup of that entry
    wr_en = 1'b1; wr_bank = 1'b1; wr_idx = 4'd5; wr_rgb = {6'h3F, 6'h00, 6'h00};
    bank = 1'b1; color = 4'd5;
    cyc();
    wr_en = 1'b0;
    cyc();
    chk("same_clk_old", 32'(rgb_out), 32'(18'b101000_111000_010000));
    cyc();
    chk("bank1_new", 32'(rgb_out), 32'(18'h3F000));
    bank = 1'b0;
    cyc(); cyc();
    chk("bank0_c5", 32'(rgb_out), 32'(18'b101000_111000_010000));

    // mono
    mono = 1'b1; color = 4'd2;
    cyc(); cyc();
    chk("mono_c2", 32'(rgb_out), 32'({6'd20, 6'd20, 6'd20}));
    color = 4'd15;
    cyc(); cyc();
    chk("mono_c15", 32'(rgb_out), 32'({6'd56, 6'd56, 6'd56}));
    mono = 1'b0;

    // reset again, re-asserted at INIT clock 10 with writes pending
    reset = 1'b1;
    cyc();
    reset = 1'b0; pixel = 1'b0;
    repeat (10) cyc();
    reset = 1'b1; wr_en = 1'b1; wr_bank = 1'b1; wr_idx = 4'd3; wr_rgb = 18'($urandom);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wr_en   = $urandom_range(0, 1) == 1;
      wr_bank = 1'($urandom);
      wr_idx  = 4'($urandom);
      wr_rgb  = 18'($urandom);
      cyc();
    end
    wr_en = 1'b0;
    chk("reinit_done", 32'(init_done), 32'd1);

    // every entry back to defaults
    pixel = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) begin
        bank = 1'(b); color = 4'(i);
        cyc();
      end
    cyc(); cyc();

    // randomized run against the model
    for (int i = 0; i < 1200; i++) begin
      ce_pix  = $urandom_range(0, 3) != 0;
      pixel   = $urandom_range(0, 7) != 0;
      color   = 4'($urandom);
      bank    = 1'($urandom);
      hsync   = $urandom_range(0, 1) == 1;
      vsync   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) mono = ~mono;
      wr_en   = $urandom_range(0, 3) == 0;
      wr_bank = 1'($urandom);
      wr_idx  = 4'($urandom);
      wr_rgb  = 18'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
